// File: rtl/noc_pkg.sv
// Flit format shared by the mesh endpoint: widths, flit type codes and head-field layout.
package noc_pkg;

    localparam int FLIT_W    = 32;
    localparam int PAYLOAD_W = 30;
    localparam int COORD_W   = 4;
    localparam int LEN_W     = 2;

    localparam int TYPE_LO   = 30;
    localparam int DEST_X_LO = 26;
    localparam int DEST_Y_LO = 22;
    localparam int SRC_X_LO  = 18;
    localparam int SRC_Y_LO  = 14;
    localparam int LEN_LO    = 12;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    // Field order mirrors the *_LO positions above, MSB first.
    typedef struct packed {
        flit_type_e         ftype;
        logic [COORD_W-1:0] dest_x;
        logic [COORD_W-1:0] dest_y;
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] src_y;
        logic [LEN_W-1:0]   len;
        logic [11:0]        rsvd;
    } head_flit_t;

    function automatic logic [FLIT_W-1:0] make_head(
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] sx,
        input logic [COORD_W-1:0] sy,
        input logic [LEN_W-1:0]   len
    );
        head_flit_t h;
        h.ftype  = FLIT_HEAD;
        h.dest_x = dx;
        h.dest_y = dy;
        h.src_x  = sx;
        h.src_y  = sy;
        h.len    = len;
        h.rsvd   = '0;
        return h;
    endfunction

endpackage

// File: rtl/noc_endpoint_if.sv
// Valid/ready flit link between the endpoint and its router's local port.
interface noc_endpoint_if;
    import noc_pkg::*;

    logic [FLIT_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/noc_fifo.sv
// Fall-through FIFO: the head entry is readable the cycle after it is written.
module noc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/noc_endpoint.sv
// Mesh endpoint: packetises core commands onto the router link and unpacks ejected flits for the core.
module noc_endpoint
    import noc_pkg::*;
#(
    parameter logic [COORD_W-1:0] XCOORD   = 4'b0001,
    parameter logic [COORD_W-1:0] YCOORD   = 4'b0001,
    parameter int                 RX_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_endpoint_if.master       inj,
    noc_endpoint_if.slave        ej,
    input  logic                 tx_cmd_valid,
    output logic                 tx_cmd_ready,
    input  logic [COORD_W-1:0]   tx_dest_x,
    input  logic [COORD_W-1:0]   tx_dest_y,
    input  logic [LEN_W-1:0]     tx_len,
    input  logic                 tx_word_valid,
    output logic                 tx_word_ready,
    input  logic [PAYLOAD_W-1:0] tx_word,
    output logic                 rx_hdr_valid,
    input  logic                 rx_hdr_ready,
    output logic [COORD_W-1:0]   rx_src_x,
    output logic [COORD_W-1:0]   rx_src_y,
    output logic [LEN_W-1:0]     rx_len,
    output logic                 rx_word_valid,
    input  logic                 rx_word_ready,
    output logic [PAYLOAD_W-1:0] rx_word,
    output logic                 rx_last,
    output logic                 rx_misroute,
    output logic [15:0]          tx_pkt_cnt,
    output logic [15:0]          rx_pkt_cnt,
    output logic [15:0]          drop_cnt
);

    typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_BODY} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_BODY, RX_DROP} rx_state_e;

    // ---------------- TX path ----------------
    tx_state_e         tx_state;
    logic [FLIT_W-1:0] tx_head_q;
    logic [LEN_W-1:0]  tx_len_q;
    logic [LEN_W-1:0]  tx_cnt;
    logic              tx_last;
    flit_type_e        tx_body_type;

    assign tx_last       = (tx_cnt == tx_len_q);
    assign tx_body_type  = tx_last ? FLIT_TAIL : FLIT_BODY;
    assign tx_cmd_ready  = (tx_state == TX_IDLE) && !rst;
    assign tx_word_ready = (tx_state == TX_BODY) && inj.ready && !rst;

    // Body flits pass straight through so a stalled router holds the core's word in place.
    always_comb begin
        inj.valid = 1'b0;
        inj.data  = tx_head_q;
        case (tx_state)
            TX_HEAD: inj.valid = !rst;
            TX_BODY: begin
                inj.valid = tx_word_valid && !rst;
                inj.data  = {tx_body_type, tx_word};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_head_q  <= '0;
            tx_len_q   <= '0;
            tx_cnt     <= '0;
            tx_pkt_cnt <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_cmd_valid) begin
                    tx_head_q <= make_head(tx_dest_x, tx_dest_y, XCOORD, YCOORD, tx_len);
                    tx_len_q  <= tx_len;
                    tx_state  <= TX_HEAD;
                end
                TX_HEAD: if (inj.ready) begin
                    tx_cnt   <= '0;
                    tx_state <= TX_BODY;
                end
                TX_BODY: if (tx_word_valid && inj.ready) begin
                    if (tx_last) begin
                        tx_state   <= TX_IDLE;
                        tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
                    end else begin
                        tx_cnt <= tx_cnt + LEN_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    rx_state_e         rx_state;
    logic [FLIT_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty, fifo_pop;
    flit_type_e        head_type;
    logic              head_is_tail, head_for_us;

    assign ej.ready = !fifo_full && !rst;

    noc_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ej.valid && ej.ready),
        .push_data (ej.data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_type    = flit_type_e'(fifo_head[FLIT_W-1:TYPE_LO]);
    assign head_is_tail = (head_type == FLIT_TAIL);
    assign head_for_us  = (fifo_head[DEST_X_LO +: COORD_W] == XCOORD) &&
                          (fifo_head[DEST_Y_LO +: COORD_W] == YCOORD);

    // RX_HDR never pops: the head was already consumed into the header registers.
    always_comb begin
        fifo_pop = 1'b0;
        if (!rst && !fifo_empty) begin
            case (rx_state)
                RX_IDLE, RX_DROP: fifo_pop = 1'b1;
                RX_BODY:          fifo_pop = rx_word_ready;
                default:          ;
            endcase
        end
    end

    assign rx_hdr_valid  = (rx_state == RX_HDR) && !rst;
    assign rx_word_valid = (rx_state == RX_BODY) && !fifo_empty && !rst;
    assign rx_word       = fifo_head[PAYLOAD_W-1:0];
    assign rx_last       = (rx_state == RX_BODY) && head_is_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_src_x    <= '0;
            rx_src_y    <= '0;
            rx_len      <= '0;
            rx_misroute <= 1'b0;
            rx_pkt_cnt  <= '0;
            drop_cnt    <= '0;
        end else begin
            rx_misroute <= 1'b0;
            case (rx_state)
                RX_IDLE: if (!fifo_empty) begin
                    if (head_type == FLIT_HEAD) begin
                        if (head_for_us) begin
                            rx_src_x <= fifo_head[SRC_X_LO +: COORD_W];
                            rx_src_y <= fifo_head[SRC_Y_LO +: COORD_W];
                            rx_len   <= fifo_head[LEN_LO +: LEN_W];
                            rx_state <= RX_HDR;
                        end else begin
                            rx_misroute <= 1'b1;
                            rx_state    <= RX_DROP;
                        end
                    end else begin
                        // Stray body/tail with no head in front of it.
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                RX_HDR: if (rx_hdr_ready) rx_state <= RX_BODY;
                RX_BODY: if (fifo_pop && head_is_tail) begin
                    rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
                    rx_state   <= RX_IDLE;
                end
                RX_DROP: if (fifo_pop && head_is_tail) begin
                    drop_cnt <= drop_cnt + 16'd1;
                    rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_endpoint.sv
// Directed-plus-random bench for noc_endpoint; expected flits come from the flit format arithmetic.
module tb_noc_endpoint;
    import noc_pkg::*;

    localparam logic [3:0] XC    = 4'b0001;
    localparam logic [3:0] YC    = 4'b0001;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_cmd_valid, tx_cmd_ready;
    logic [3:0]  tx_dest_x, tx_dest_y;
    logic [1:0]  tx_len;
    logic        tx_word_valid, tx_word_ready;
    logic [29:0] tx_word;
    logic        rx_hdr_valid, rx_hdr_ready;
    logic [3:0]  rx_src_x, rx_src_y;
    logic [1:0]  rx_len;
    logic        rx_word_valid, rx_word_ready;
    logic [29:0] rx_word;
    logic        rx_last, rx_misroute;
    logic [15:0] tx_pkt_cnt, rx_pkt_cnt, drop_cnt;

    noc_endpoint_if inj_if ();
    noc_endpoint_if ej_if ();

    int vectors = 0, miscompares = 0;
    int m_tx = 0, m_rx = 0, m_drop = 0, n_mis = 0;
    logic [31:0] ej_q[$];
    logic [9:0]  exp_hdr[$];
    logic [30:0] exp_word[$];

    always #5 clk = ~clk;

    noc_endpoint #(.XCOORD(XC), .YCOORD(YC), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .inj(inj_if), .ej(ej_if),
        .tx_cmd_valid(tx_cmd_valid), .tx_cmd_ready(tx_cmd_ready),
        .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_len(tx_len),
        .tx_word_valid(tx_word_valid), .tx_word_ready(tx_word_ready), .tx_word(tx_word),
        .rx_hdr_valid(rx_hdr_valid), .rx_hdr_ready(rx_hdr_ready),
        .rx_src_x(rx_src_x), .rx_src_y(rx_src_y), .rx_len(rx_len),
        .rx_word_valid(rx_word_valid), .rx_word_ready(rx_word_ready),
        .rx_word(rx_word), .rx_last(rx_last), .rx_misroute(rx_misroute),
        .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt)
    );

    // Flit images from field positions: type at 30, dest X/Y at 26/22, src X/Y at 18/14, len at 12.
    function automatic logic [31:0] head_flit(input longint dx, dy, sx, sy, len);
        return 32'((64'd1 << 30) + (dx << 26) + (dy << 22) + (sx << 18) + (sy << 14) + (len << 12));
    endfunction

    function automatic logic [31:0] body_flit(input longint p, input bit last);
        return 32'((last ? 64'd3 : 64'd2) * (64'd1 << 30) + p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters();
        chk("tx_pkt_cnt", tx_pkt_cnt, m_tx);
        chk("rx_pkt_cnt", rx_pkt_cnt, m_rx);
        chk("drop_cnt",   drop_cnt,   m_drop);
    endtask

    task automatic chk_reset_state();
        chk("rst_inj_valid",    inj_if.valid,  0);
        chk("rst_ej_ready",     ej_if.ready,   0);
        chk("rst_tx_cmd_ready", tx_cmd_ready,  0);
        chk("rst_hdr_valid",    rx_hdr_valid,  0);
        chk("rst_word_valid",   rx_word_valid, 0);
        chk("rst_misroute",     rx_misroute,   0);
        chk_counters();
    endtask

    // Sends one command and streams its body; stop_after >= 0 abandons after that many flits.
    task automatic tx_packet(input logic [3:0] dx, dy, input logic [1:0] len,
                             input bit stall, input int stop_after);
        logic [31:0] exp[$];
        logic [29:0] w[4];
        int k, n;
        k = 0;
        n = 0;
        for (int i = 0; i < 4; i++) w[i] = 30'($urandom);
        exp.push_back(head_flit(dx, dy, XC, YC, len));
        for (int i = 0; i <= int'(len); i++) exp.push_back(body_flit(w[i], i == int'(len)));
        tx_cmd_valid = 1'b1; tx_dest_x = dx; tx_dest_y = dy; tx_len = len; inj_if.ready = 1'b0;
        #1 chk("tx_cmd_ready", tx_cmd_ready, 1);
        @(posedge clk); #1;
        tx_cmd_valid = 1'b0;
        tx_dest_x = 4'($urandom); tx_dest_y = 4'($urandom); tx_len = 2'($urandom);
        tx_word_valid = 1'b1;
        while (k < exp.size() && k != stop_after && n < 200) begin
            inj_if.ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_word = w[(k == 0) ? 0 : k - 1];
            #1;
            chk("inj_valid", inj_if.valid, 1);
            chk("inj_data", inj_if.data, exp[k]);
            chk("tx_word_ready", tx_word_ready, (k > 0) && inj_if.ready);
            if (inj_if.ready) k++;
            @(posedge clk); #1;
            n++;
        end
        tx_word_valid = 1'b0;
        inj_if.ready = 1'b1;
        chk("tx_flits_sent", k, (stop_after < 0) ? exp.size() : stop_after);
        if (stop_after < 0) begin
            m_tx++;
            #1;
            chk("inj_idle", inj_if.valid, 0);
            chk("tx_cmd_ready_idle", tx_cmd_ready, 1);
            chk("tx_pkt_cnt", tx_pkt_cnt, m_tx);
        end
    endtask

    task automatic push_pkt(input bit good, input logic [1:0] len);
        logic [3:0] sx, sy, dx, dy;
        logic [29:0] p;
        sx = 4'($urandom); sy = 4'($urandom); dx = XC; dy = YC;
        if (!good) begin
            dx = 4'($urandom); dy = 4'($urandom);
            if (dx == XC && dy == YC) dy = ~YC;
        end
        ej_q.push_back(head_flit(dx, dy, sx, sy, len));
        if (good) begin exp_hdr.push_back({sx, sy, len}); m_rx++; end
        else begin m_drop++; n_mis++; end
        for (int i = 0; i <= int'(len); i++) begin
            p = 30'($urandom);
            ej_q.push_back(body_flit(p, i == int'(len)));
            if (good) exp_word.push_back({i == int'(len), p});
        end
    endtask

    // Plays ej_q into the endpoint and scores core-side outputs in order.
    task automatic rx_run(input int hdr_hold, input bit rand_ready);
        int n, idle, accepted, mis;
        n = 0; idle = 0; accepted = 0; mis = 0;
        while (n < 400 && idle < 4) begin
            ej_if.valid   = (ej_q.size() > 0);
            ej_if.data    = (ej_q.size() > 0) ? ej_q[0] : 32'h0;
            rx_hdr_ready  = (n >= hdr_hold);
            rx_word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (hdr_hold > 0 && n == hdr_hold - 1) begin
                // FIFO full plus the head already latched into the header registers.
                chk("ej_backpressure", ej_if.ready, 0);
                chk("ej_accepted_in_hold", accepted, DEPTH + 1);
            end
            if (ej_if.valid && ej_if.ready) begin
                void'(ej_q.pop_front());
                accepted++;
            end
            if (rx_hdr_valid && rx_hdr_ready) begin
                if (exp_hdr.size() == 0) chk("rx_hdr_unexpected", rx_hdr_valid, 0);
                else chk("rx_hdr", {rx_src_x, rx_src_y, rx_len}, exp_hdr.pop_front());
            end
            if (rx_word_valid && rx_word_ready) begin
                if (exp_word.size() == 0) chk("rx_word_unexpected", rx_word_valid, 0);
                else chk("rx_word", {rx_last, rx_word}, exp_word.pop_front());
            end
            if (rx_misroute) mis++;
            idle = (ej_q.size() == 0 && exp_hdr.size() == 0 && exp_word.size() == 0) ? idle + 1 : 0;
            @(posedge clk); #1;
            n++;
        end
        ej_if.valid = 1'b0;
        chk("rx_outstanding", ej_q.size() + exp_hdr.size() + exp_word.size(), 0);
        chk("rx_misroute_pulses", mis, n_mis);
        n_mis = 0;
        chk_counters();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tx_cmd_valid = 0; tx_dest_x = 0; tx_dest_y = 0; tx_len = 0;
        tx_word_valid = 0; tx_word = 0; rx_hdr_ready = 0; rx_word_ready = 0;
        inj_if.ready = 0; ej_if.valid = 0; ej_if.data = 0;

        repeat (2) @(posedge clk);
        #1 chk_reset_state();
        rst = 1'b0;
        #1;
        chk("post_rst_ej_ready", ej_if.ready, 1);
        chk("post_rst_cmd_ready", tx_cmd_ready, 1);
        @(posedge clk); #1;

        // TX: reference packet, loopback, non-one-hot dest, then random stalls.
        tx_packet(4'b0100, 4'b0010, 2'd2, 1'b0, -1);
        tx_packet(XC, YC, 2'd0, 1'b1, -1);
        tx_packet(4'b0110, 4'b0000, 2'd3, 1'b1, -1);
        for (int i = 0; i < 6; i++)
            tx_packet(4'($urandom), 4'($urandom), 2'($urandom), 1'b1, -1);

        // RX: single-word packet from (1000,0100).
        ej_q.push_back(head_flit(XC, YC, 4'b1000, 4'b0100, 0));
        ej_q.push_back(body_flit(30'h3, 1'b1));
        exp_hdr.push_back({4'b1000, 4'b0100, 2'd0});
        exp_word.push_back({1'b1, 30'h3});
        m_rx++;
        rx_run(0, 1'b0);

        // RX: misrouted packet to (0010,0001).
        ej_q.push_back(head_flit(4'b0010, 4'b0001, 4'b0100, 4'b0100, 2));
        ej_q.push_back(body_flit(30'h11, 1'b0));
        ej_q.push_back(body_flit(30'h22, 1'b0));
        ej_q.push_back(body_flit(30'h33, 1'b1));
        m_drop++; n_mis++;
        rx_run(0, 1'b0);

        // RX: stray body and tail flits with no head.
        ej_q.push_back(body_flit(30'h5, 1'b0));
        ej_q.push_back(body_flit(30'h6, 1'b1));
        m_drop += 2;
        rx_run(0, 1'b0);

        // RX: header held off while six flits are offered.
        push_pkt(1'b1, 2'd0);
        push_pkt(1'b1, 2'd2);
        rx_run(12, 1'b0);

        // RX: random mix of local and misrouted packets with random core stalls.
        for (int i = 0; i < 8; i++) push_pkt($urandom_range(0, 3) != 0, 2'($urandom));
        rx_run(0, 1'b1);

        // Reset in the middle of a TX body.
        tx_packet(4'b0010, 4'b0001, 2'd3, 1'b1, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        m_tx = 0; m_rx = 0; m_drop = 0;
        chk_reset_state();
        rst = 1'b0;
        #1;
        chk("abort_inj_valid", inj_if.valid, 0);
        chk("abort_cmd_ready", tx_cmd_ready, 1);
        chk("abort_ej_ready", ej_if.ready, 1);
        @(posedge clk); #1;
        tx_packet(4'b1000, 4'b0100, 2'd1, 1'b1, -1);
        push_pkt(1'b1, 2'd1);
        rx_run(0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
